// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/down_counter_if.sv
// Load handshake bundle: requester drives master, counter is slave.
interface down_counter_if #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
);
    import down_counter_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  load_value;
    logic [STEP_W-1:0] load_step;
    logic              load_sat;

    modport master (
        output load_valid,
        output load_value,
        output load_step,
        output load_sat,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  load_step,
        input  load_sat,
        output load_ready
    );

endinterface

// File: rtl/down_counter_step_subtractor.sv
// WIDTH-bit minuend minus zero-extended STEP_W-bit step, with borrow out.
module step_subtractor
    import down_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [STEP_W-1:0] i_b,
    output logic [WIDTH-1:0]  o_diff,
    output logic              o_borrow
);

    logic [WIDTH:0] w_full;

    assign w_full   = {1'b0, i_a} - {{(WIDTH + 1 - STEP_W){1'b0}}, i_b};
    assign o_diff   = w_full[WIDTH-1:0];
    assign o_borrow = w_full[WIDTH];

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter with step, saturate/wrap mode and tc/wrap pulses.
// Optional DOWN_COUNTER_AUTO_RELOAD_EN: reload on terminal, adds i_stop.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    down_counter_if.slave    load_if,
    input  logic             i_en,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    input  logic             i_stop,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tc,
    output logic             o_wrap
);

    state_t            r_state;
    logic [WIDTH-1:0]  r_count;
    logic [STEP_W-1:0] r_step;
    logic              r_mode;
    logic              r_tc;
    logic              r_wrap;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0]  r_reload;
`endif

    logic [WIDTH-1:0]  w_diff;
    logic              w_borrow;
    logic              w_last;
    logic [STEP_W-1:0] w_step_eff;
    logic              w_halt;

    step_subtractor #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_sub (
        .i_a      (r_count),
        .i_b      (r_step),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // count <= step is exactly: borrow out, or a zero difference
    assign w_last     = w_borrow || (w_diff == '0);
    assign w_step_eff = (load_if.load_step == '0) ? STEP_W'(1)
                                                  : load_if.load_step;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    assign w_halt = i_stop;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_step  <= STEP_W'(1);
            r_mode  <= MODE_SAT;
            r_tc    <= 1'b0;
            r_wrap  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_tc   <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (load_if.load_valid) begin
                        r_count <= load_if.load_value;
                        r_step  <= w_step_eff;
                        r_mode  <= load_if.load_sat;
                        r_state <= RUN;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        r_reload <= load_if.load_value;
`endif
                    end
                end
                RUN: begin
                    if (w_halt) begin
                        r_state <= DONE;
                    end else if (i_en) begin
                        if (!w_last) begin
                            r_count <= w_diff;
                        end else begin
                            r_tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            r_count <= r_reload;
`else
                            r_count <= (r_mode == MODE_SAT) ? '0 : w_diff;
                            r_wrap  <= (r_mode == MODE_WRAP) && w_borrow;
                            r_state <= DONE;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_if.load_ready = (r_state != RUN);
    assign o_count = r_count;
    assign o_busy  = (r_state == RUN);
    assign o_done  = (r_state == DONE);
    assign o_tc    = r_tc;
    assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_down_counter.sv
// Directed + random bench for down_counter against a behavioural model.
module tb_down_counter;

  localparam int W  = 32;
  localparam int SW = 8;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic stop;
  logic [W-1:0] count;
  logic busy, done, tc, wrap;

  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(W), .STEP_W(SW)) lif ();

  down_counter #(.WIDTH(W), .STEP_W(SW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .load_if (lif.slave),
    .i_en    (en),
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    .i_stop  (stop),
`endif
    .o_count (count),
    .o_busy  (busy),
    .o_done  (done),
    .o_tc    (tc),
    .o_wrap  (wrap)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state: running flag, finished flag, plain integer count
  logic [W-1:0] m_count;
  bit m_run, m_fin, m_tc, m_wrap, m_sat;
  int unsigned m_step;
  logic [W-1:0] m_reload;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_tc   = 0;
    m_wrap = 0;
    if (rst) begin
      m_count = '0; m_run = 0; m_fin = 0;
      m_step = 1; m_sat = 1; m_reload = '0;
    end else if (!m_run) begin
      if (lif.load_valid) begin
        m_count  = lif.load_value;
        m_reload = lif.load_value;
        m_step   = (lif.load_step == 0) ? 1 : int'(lif.load_step);
        m_sat    = lif.load_sat;
        m_run = 1; m_fin = 0;
      end
    end else if (AUTO && stop) begin
      m_run = 0; m_fin = 1;
    end else if (en) begin
      if (longint'(m_count) > longint'(m_step)) begin
        m_count = m_count - W'(m_step);
      end else begin
        m_tc = 1;
        if (AUTO) begin
          m_count = m_reload;
        end else begin
          m_wrap  = !m_sat && (longint'(m_count) < longint'(m_step));
          m_count = m_sat ? '0 : m_count - W'(m_step);
          m_run = 0; m_fin = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(m_count));
    chk("busy",  64'(busy),  64'(m_run));
    chk("done",  64'(done),  64'(m_fin));
    chk("tc",    64'(tc),    64'(m_tc));
    chk("wrap",  64'(wrap),  64'(m_wrap));
    chk("ready", 64'(lif.load_ready), 64'(!m_run));
  endtask

  task automatic cyc(input logic r, input logic lv,
                     input logic [W-1:0] v, input logic [SW-1:0] s,
                     input logic sat, input logic e, input logic sp);
    rst = r;
    lif.load_valid = lv;
    lif.load_value = v;
    lif.load_step  = s;
    lif.load_sat   = sat;
    en   = e;
    stop = sp;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input logic [W-1:0] v, input logic [SW-1:0] s,
                      input logic sat);
    cyc(0, 1, v, s, sat, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 1, 0);
  endtask

  initial begin
    int k;
    rst = 1; en = 0; stop = 0;
    lif.load_valid = 0; lif.load_value = '0;
    lif.load_step = '0; lif.load_sat = 0;
    m_count = '0; m_run = 0; m_fin = 0; m_tc = 0; m_wrap = 0;
    m_step = 1; m_sat = 1; m_reload = '0;

    cyc(1, 0, '0, '0, 0, 0, 0);
    cyc(1, 1, 32'd55, 8'd2, 0, 1, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(lif.load_ready), 64'd1);

    // 10 / step 1, saturate: terminal 10 cycles after load
    load(32'd10, 8'd1, 1);
    k = 0;
    do begin
      run(1);
      k++;
    end while (!tc && k < 40);
    chk("t1_latency", 64'(k), 64'd10);
    chk("t1_count", 64'(count), AUTO ? 64'd10 : 64'd0);

    // 7 / step 3, wrap
    load(32'd7, 8'd3, 0);
    run(3);
    chk("t2_count", 64'(count), AUTO ? 64'd7 : 64'hFFFF_FFFE);
    chk("t2_wrap", 64'(wrap), AUTO ? 64'd0 : 64'd1);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);

    // 7 / step 3, saturate
    load(32'd7, 8'd3, 1);
    run(3);
    chk("t3_tc", 64'(tc), 64'd1);
    chk("t3_wrap", 64'(wrap), 64'd0);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);

    // gated enable with an ignored load during RUN
    load(32'd5, 8'd1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'd99, 8'd1, 1, !i[0], 0);
    chk("t4_count", 64'(count), 64'd3);
    run(3);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);
    load(32'd99, 8'd1, 1);
    chk("t4_reload", 64'(count), 64'd99);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);
    else run(99);

    // load 0 with step 0
    load(32'd0, 8'd0, 1);
    run(1);
    chk("t5_sat_tc", 64'(tc), 64'd1);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);
    load(32'd0, 8'd0, 0);
    run(1);
    chk("t5_wrap_cnt", 64'(count), AUTO ? 64'd0 : 64'hFFFF_FFFF);
    if (AUTO) cyc(0, 0, '0, '0, 0, 0, 1);

    // reset mid-count
    load(32'd5, 8'd1, 1);
    run(2);
    cyc(1, 0, '0, '0, 0, 1, 0);
    chk("t6_tc", 64'(tc), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    cyc(0, 0, '0, '0, 0, 0, 0);

    if (AUTO) begin
      load(32'd2, 8'd1, 1);
      run(4);
      cyc(0, 0, '0, '0, 0, 1, 1);
      chk("t7_done", 64'(done), 64'd1);
    end

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] v;
      logic [SW-1:0] s;
      v = ($urandom % 4 == 0) ? W'($urandom) : W'($urandom % 24);
      s = ($urandom % 4 == 0) ? SW'($urandom) : SW'($urandom % 6);
      cyc(($urandom % 80) == 0, ($urandom % 3) == 0, v, s,
          1'($urandom), ($urandom % 4) != 0, ($urandom % 20) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Parametrised, loadable down-counter with programmable step size, saturate or wrap-on-underflow mode, terminal-count pulse and a valid/ready load handshake. It generalises the fixed decrement-by-one datapath into a sequential block. The control unit uses it for multi-cycle operation timers, loop counts and stall windows. It sits beside the ALU datapath and is driven from the controller FSM.

## Interface
- WIDTH, 32, counter width in bits
- STEP_W, 8, width of the programmable step
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load request
- load_ready  out  1  block can accept a load
- load_value  in  WIDTH  start count
- load_step  in  STEP_W  decrement per enabled cycle; 0 is treated as 1
- load_sat  in  1  1 = saturate at 0, 0 = wrap modulo 2^WIDTH
- en  in  1  count enable, sampled in RUN only
- count  out  WIDTH  current count, registered
- busy  out  1  high in RUN
- done  out  1  high in DONE
- tc  out  1  one-cycle pulse on terminal decrement
- wrap  out  1  one-cycle pulse on terminal decrement that underflowed in wrap mode
- One clock domain; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, count 0, busy 0, done 0, tc 0, wrap 0, load_ready 1. Stored step and mode registers are cleared to 1 and saturate.
- load_ready is 1 in IDLE and DONE, and 0 in RUN.
- Load handshake: when load_valid && load_ready, the block registers load_value into count, registers step and mode, and moves to RUN. load_value = 0 is legal.
- RUN with en = 0: all state holds.
- RUN with en = 1 and count > step: count ← count − step. Stay in RUN.
- RUN with en = 1 and count ≤ step: this is the terminal decrement. tc pulses.
  - Saturate mode: count ← 0.
  - Wrap mode: count ← (count − step) mod 2^WIDTH. wrap pulses only if count < step.
  - Next state is DONE.
- DONE holds count. A new load is accepted directly from DONE. done clears on that load.
- A load presented during RUN is ignored, because load_ready = 0. Requesters must hold load_valid until they see ready.
- Arithmetic: step is zero-extended to WIDTH. The borrow out of the WIDTH-bit subtract defines underflow.

## Timing
- A load accepted at edge N makes count = load_value after edge N. busy rises after the same edge.
- The first decrement can occur at edge N+1.
- Latency to done for a constant en = 1 is ceil(load_value / step) cycles after load, with a minimum of 1 (load_value 0 counts as 1).
- tc and wrap are registered. They are high for exactly the one cycle following the terminal edge, coincident with done first rising.
- Reset asserted mid-RUN returns every output to its reset value at the next edge. No tc is generated.
- Reset has priority over load and en.

## Configuration
- DOWN_COUNTER_AUTO_RELOAD_EN
- When defined:
  - A terminal decrement reloads count from the stored load_value instead of saturating or wrapping.
  - tc still pulses, wrap never pulses, and the state stays RUN.
  - An extra input port stop (1 bit) is added. stop in RUN moves to DONE at the next edge with count held and no tc. stop has priority over en.
- When undefined: the behaviour is as in Operation and there is no stop port.

## Structure
- Package down_counter_pkg holds:
  - the typedef enum logic [1:0] state_t {IDLE, RUN, DONE};
  - the mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
- One sub-module, step_subtractor: combinational WIDTH-bit minuend minus zero-extended STEP_W-bit subtrahend. Outputs are the difference and the borrow.
- The FSM, registers and pulse generation live in down_counter.

## Test plan
- Reset, then load 10 with step 1, saturate, en held high → count 9..1 then 0. tc is high one cycle, 10 cycles after load, and done rises with it.
- Load 7 with step 3, wrap → count 4, 1, then 0xFFFF_FFFE. tc and wrap pulse together and done is set.
- Load 7 with step 3, saturate → count 4, 1, 0. tc pulses, wrap stays 0.
- Load 5, toggle en 1,0,1,0, assert load_valid with value 99 during RUN → count decrements only on en cycles, the load is ignored and load_ready stays 0. Then from DONE, load 99 is accepted.
- Load 0 with step 0 → step is treated as 1. The first enabled cycle is terminal: saturate gives count 0; wrap gives 0xFFFF_FFFF with wrap pulsing.
- Reset asserted mid-count at count 3 → count 0, state IDLE, no tc. With DOWN_COUNTER_AUTO_RELOAD_EN: load 2 gives count 1, 2, 1, 2 with tc every 2 cycles, and stop moves to DONE.
